// File: rtl/ks8_seq_add32.sv
// Sequential W-bit adder: one 8-bit Kogge-Stone slice adder, time-shared
// over NSLICE cycles, with valid/ready handshakes on both sides.

module ks8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci,
   output logic [7:0] sum,
   output logic       co
);

   logic [7:0] p0, g0, p1, g1, g2, g3;
   logic [7:4] p2;
   logic [8:0] c;

   always_comb begin
      p0 = a ^ b;
      g0 = a & b;
      // fold carry-in into bit 0 so the prefix tree yields true carries
      g0[0] = g0[0] | (p0[0] & ci);
      p1 = p0;
      g1 = g0;
      for (int i = 1; i < 8; i++) begin
         g1[i] = g0[i] | (p0[i] & g0[i-1]);
         p1[i] = p0[i] & p0[i-1];
      end
      g2 = g1;
      for (int i = 2; i < 8; i++) begin
         g2[i] = g1[i] | (p1[i] & g1[i-2]);
      end
      for (int i = 4; i < 8; i++) begin
         p2[i] = p1[i] & p1[i-2];
      end
      g3 = g2;
      for (int i = 4; i < 8; i++) begin
         g3[i] = g2[i] | (p2[i] & g2[i-4]);
      end
      c   = {g3, ci};
      sum = p0 ^ c[7:0];
      co  = c[8];
   end

endmodule

module ks8_seq_add32 #(
   parameter int NSLICE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NSLICE-1:0] x1,
   input  logic [8*NSLICE-1:0] x2,
   input  logic                cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NSLICE-1:0] s,
   output logic                cout
);

   localparam int W  = 8 * NSLICE;
   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_q, b_q;
   logic          carry_q;
   logic [7:0]    sa, sb, ks_sum;
   logic          ks_co;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      sa = '0;
      sb = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx == IW'(i)) begin
            sa = a_q[8*i +: 8];
            sb = b_q[8*i +: 8];
         end
      end
   end

   ks8 u_ks8 (
      .a   (sa),
      .b   (sb),
      .ci  (carry_q),
      .sum (ks_sum),
      .co  (ks_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         s       <= '0;
         cout    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= x1;
                  b_q     <= x2;
                  carry_q <= cin;
                  idx     <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NSLICE; i++) begin
                  if (idx == IW'(i)) s[8*i +: 8] <= ks_sum;
               end
               carry_q <= ks_co;
               if (idx == IW'(NSLICE - 1)) begin
                  cout  <= ks_co;
                  idx   <= '0;
                  state <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule
